// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage register with valid/ready handshake
// and a 1-entry skid buffer. The main register drives the outputs directly;
// the skid register absorbs the entry accepted while the main register is
// full and not being popped, so in_ready depends on a flop only.
// Optional build macro: PIPE_STAGE_BUF_STAT_EN (stall/kill statistics counters).
module pipe_stage_buf #(
  parameter int unsigned         DATA_W     = 128,
  parameter int unsigned         PC_W       = 32,
  parameter logic [PC_W-1:0]     HANDLER_PC = 'h0000_4180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_kill
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [PC_W-1:0]   out_pc_q,    out_pc_d;
  logic              s_valid_q,   s_valid_d;
  logic [DATA_W-1:0] s_data_q,    s_data_d;
  logic [PC_W-1:0]   s_pc_q,      s_pc_d;

  logic acc;
  logic pop;
  logic kill;

  assign in_ready  = ~s_valid_q;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid_q & out_ready;
  assign kill      = req | flush;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_pc    = out_pc_q;

  // Next-state for main and skid registers: kill, refill from skid/input, or park in skid.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_pc_d    = out_pc_q;
    s_valid_d   = s_valid_q;
    s_data_d    = s_data_q;
    s_pc_d      = s_pc_q;
    if (kill) begin
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_pc_d    = req ? HANDLER_PC : '0;
      s_valid_d   = 1'b0;
      s_data_d    = '0;
      s_pc_d      = '0;
    end else if (!out_valid_q || pop) begin
      if (s_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data_q;
        out_pc_d    = s_pc_q;
        s_valid_d   = 1'b0;
      end else if (acc) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_pc_d    = in_pc;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (acc) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
      s_pc_d    = in_pc;
    end
  end

  // Stage storage with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_pc_q    <= '0;
      s_valid_q   <= 1'b0;
      s_data_q    <= '0;
      s_pc_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_pc_q    <= out_pc_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
      s_pc_q      <= s_pc_d;
    end
  end

`ifdef PIPE_STAGE_BUF_STAT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] kills_q, kills_d;

  // Saturating stall and kill counters, cleared only by reset.
  always_comb begin
    stall_d = stall_q;
    kills_d = kills_q;
    if (out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    if (kill && (kills_q != '1)) begin
      kills_d = kills_q + 32'd1;
    end
  end

  // Counter storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      kills_q <= '0;
    end else begin
      stall_q <= stall_d;
      kills_q <= kills_d;
    end
  end

  assign stat_stall = stall_q;
  assign stat_kill  = kills_q;
`else
  assign stat_stall = '0;
  assign stat_kill  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: the driver pushes each entry the stage
// should accept into a FIFO model; a negedge monitor pops and compares.
module tb_pipe_stage_buf;

  localparam int unsigned DW = 40;
  localparam int unsigned PW = 32;
  localparam logic [PW-1:0] HPC = 32'h0000_4180;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req, flush;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_pc;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_pc;
  logic [31:0]   stat_stall, stat_kill;

  pipe_stage_buf #(.DATA_W(DW), .PC_W(PW), .HANDLER_PC(HPC)) dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
    .stat_stall(stat_stall), .stat_kill(stat_kill)
  );

  always #5 clk = ~clk;

  ent_t          exp_q[$];
  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;
  logic [PW-1:0] last_pc = '0;
  logic [DW-1:0] last_data = '0;
  logic [31:0]   exp_stall = '0;
  logic [31:0]   exp_kill = '0;
  bit            run_mon = 1'b0;
  bit            will_acc = 1'b0;
  logic [PW-1:0] pc_ctr = 32'h3000;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable here; the inputs seen now apply at the next posedge.
  always @(negedge clk) begin
    if (run_mon) begin
      int unsigned occ;
      occ = exp_q.size();
      check("out_valid", 128'(out_valid), 128'(occ > 0));
      check("in_ready", 128'(in_ready), 128'(occ < 2));
      if (occ > 0) begin
        last_pc   = exp_q[0].pc;
        last_data = exp_q[0].data;
      end
      check("out_pc", 128'(out_pc), 128'(last_pc));
      check("out_data", 128'(out_data), 128'(last_data));
      check("stat_stall", 128'(stat_stall), 128'(exp_stall));
      check("stat_kill", 128'(stat_kill), 128'(exp_kill));
`ifdef PIPE_STAGE_BUF_STAT_EN
      if (occ > 0 && !out_ready) exp_stall = exp_stall + 32'd1;
      if (req || flush) exp_kill = exp_kill + 32'd1;
`endif
      if (occ > 0 && out_ready) void'(exp_q.pop_front());
      if (req || flush) begin
        exp_q.delete();
        last_pc   = req ? HPC : '0;
        last_data = '0;
      end
    end
  end

  // One cycle of stimulus; the accepted entry joins the model after the edge.
  task automatic step(input logic iv, input logic [PW-1:0] pc, input logic [DW-1:0] d,
                      input logic ordy, input logic rq, input logic fl);
    ent_t e;
    in_valid  = iv;
    in_pc     = pc;
    in_data   = d;
    out_ready = ordy;
    req       = rq;
    flush     = fl;
    will_acc  = iv && (exp_q.size() < 2) && !(rq || fl);
    e.pc      = pc;
    e.data    = d;
    @(posedge clk);
    #1;
    if (will_acc) exp_q.push_back(e);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  initial begin
    logic [PW-1:0] pc_n;
    logic [DW-1:0] d_n;
    logic          iv_n, hold, ordy_bias;

    reset = 1'b0; req = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; in_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_pc", 128'(out_pc), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    run_mon = 1'b1;

    // Back-to-back stream with downstream always ready.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pc_ctr, rnd_data(), 1'b1, 1'b0, 1'b0);
      pc_ctr = pc_ctr + 32'd4;
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Randomised traffic with upstream holding offers that were not taken.
    ordy_bias = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) ordy_bias = ($urandom_range(0, 1) == 1);
      hold = in_valid && !will_acc && !(req || flush);
      if (hold) begin
        iv_n = 1'b1;
        pc_n = in_pc;
        d_n  = in_data;
      end else begin
        iv_n = ($urandom_range(0, 3) != 0);
        pc_n = pc_ctr;
        d_n  = rnd_data();
        pc_ctr = pc_ctr + 32'd4;
      end
      step(iv_n, pc_n, d_n,
           ordy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
    end

    // Fill main and skid, offer a third, then redirect while full.
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h3000, rnd_data(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3004, rnd_data(), 1'b0, 1'b0, 1'b0);
    d_n = rnd_data();
    step(1'b1, 32'h3008, d_n, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3008, d_n, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    // Drain with skid refill order, then req+flush together, then flush alone.
    step(1'b1, 32'h3010, rnd_data(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3014, rnd_data(), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Five stalled cycles followed by one flush.
    step(1'b1, 32'h3100, rnd_data(), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while both registers hold entries.
    step(1'b1, 32'h3200, rnd_data(), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3204, rnd_data(), 1'b0, 1'b0, 1'b0);
    run_mon = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(1));
    check("arst_out_pc", 128'(out_pc), 128'(0));
    check("arst_out_data", 128'(out_data), 128'(0));
    check("arst_stat_stall", 128'(stat_stall), 128'(0));
    check("arst_stat_kill", 128'(stat_kill), 128'(0));
    in_valid = 1'b0; req = 1'b0; flush = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    last_pc = '0; last_data = '0; exp_stall = '0; exp_kill = '0; will_acc = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    run_mon = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pc_ctr, rnd_data(), (i > 2), 1'b0, 1'b0);
      pc_ctr = pc_ctr + 32'd4;
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    run_mon = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
